wb_port_arbiter: RTL

- Arbitrates the single register-file write port between two sources:
  - the execute path: ALU results and link-PC writes;
  - the memory load-return path.
- Buffers execute writes in a small FIFO. Memory returns have priority.
- An anti-starvation counter guarantees forward progress for buffered execute writes.
- Drives the registered select code, data words, address and enable that feed the 3:1 writeback data selector and the register-file write port.

---
 rtl/wb_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: memory load returns win over buffered execute writes,
// with a starvation counter that periodically forces the execute FIFO head out.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        exe_valid,
  output logic        exe_ready,
  input  logic        exe_kind,
  input  logic [4:0]  exe_addr,
  input  logic [31:0] exe_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data_in,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [1:0]  wb_sel,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_data,
  output logic [31:0] wb_pc_data,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [SW-1:0] C_LIMIT = SW'(STARVE_LIMIT);

  logic        r_kind_q [DEPTH];
  logic [4:0]  r_addr_q [DEPTH];
  logic [31:0] r_data_q [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;

  logic        r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [1:0]  r_wb_sel;
  logic [31:0] r_wb_mem_data, r_wb_alu_data, r_wb_pc_data;

  logic        w_empty, w_accept, w_mem_grant, w_pop, w_bypass, w_push, w_exe_issue;
  logic        w_iss_kind;
  logic [4:0]  w_iss_addr;
  logic [31:0] w_iss_data;

  // Flow control depends only on registered state so ready never loops back through valid.
  assign w_empty     = (r_count == '0);
  assign exe_ready   = (r_count < C_DEPTH);
  assign mem_ready   = (r_starve != C_LIMIT);
  assign busy        = !w_empty;

  assign w_accept    = exe_valid && exe_ready && !flush;
  assign w_mem_grant = mem_valid && mem_ready;
  assign w_pop       = !w_mem_grant && !w_empty && !flush;
  assign w_bypass    = !w_mem_grant && w_empty && w_accept;
  assign w_push      = w_accept && !w_bypass;
  assign w_exe_issue = w_pop || w_bypass;

  always_comb begin
    w_iss_kind = r_kind_q[r_rptr];
    w_iss_addr = r_addr_q[r_rptr];
    w_iss_data = r_data_q[r_rptr];
    if (w_empty) begin
      w_iss_kind = exe_kind;
      w_iss_addr = exe_addr;
      w_iss_data = exe_data;
    end
  end

  // FIFO payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_kind_q[r_wptr] <= exe_kind;
      r_addr_q[r_wptr] <= exe_addr;
      r_data_q[r_wptr] <= exe_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_empty || w_pop)   r_starve <= '0;
      else if (w_mem_grant)   r_starve <= r_starve + 1'b1;
    end
  end

  // Registered writeback outputs: one cycle from grant to wb_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en       <= 1'b0;
      r_wb_sel      <= 2'b00;
      r_wb_addr     <= '0;
      r_wb_mem_data <= '0;
      r_wb_alu_data <= '0;
      r_wb_pc_data  <= '0;
    end else if (w_mem_grant) begin
      r_wb_en       <= 1'b1;
      r_wb_sel      <= 2'b11;
      r_wb_addr     <= mem_addr;
      r_wb_mem_data <= mem_data_in;
    end else if (w_exe_issue) begin
      r_wb_en   <= 1'b1;
      r_wb_sel  <= w_iss_kind ? 2'b01 : 2'b10;
      r_wb_addr <= w_iss_addr;
      if (w_iss_kind) r_wb_pc_data  <= w_iss_data;
      else            r_wb_alu_data <= w_iss_data;
    end else begin
      r_wb_en  <= 1'b0;
      r_wb_sel <= 2'b00;
    end
  end

  assign wb_en       = r_wb_en;
  assign wb_sel      = r_wb_sel;
  assign wb_addr     = r_wb_addr;
  assign wb_mem_data = r_wb_mem_data;
  assign wb_alu_data = r_wb_alu_data;
  assign wb_pc_data  = r_wb_pc_data;

endmodule
